// File: rtl/register_controller.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, optional hard-wired zero register, async active-low clear.
module reg_cell #(
   parameter int REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [REG_WIDTH-1:0] d,
   output logic [REG_WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (we) q <= d;
   end
endmodule

module reg_read_port #(
   parameter int REG_WIDTH  = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs,
   input  logic [ADDR_WIDTH-1:0]              addr,
   output logic [REG_WIDTH-1:0]               data
);
   logic in_range;

   // Widen by one bit so a power-of-two NUM_REGS still fits the compare.
   assign in_range = {1'b0, addr} < (ADDR_WIDTH+1)'(NUM_REGS);

   always_comb begin
      data = '0;
      if (in_range) data = regs[addr];
   end
endmodule

module register_controller #(
   parameter int REG_WIDTH       = 32,
   parameter int NUM_REGS        = 32,
   parameter int ADDR_WIDTH      = $clog2(NUM_REGS),
   parameter bit REG_ZERO_GROUND = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [REG_WIDTH-1:0]  write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr_0,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   output logic [REG_WIDTH-1:0]  read_data_0,
   output logic [REG_WIDTH-1:0]  read_data_1
);
   localparam int NUM_READ = 2;

   logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs;
   logic [NUM_REGS-1:0]                 we;
   logic [NUM_READ-1:0][ADDR_WIDTH-1:0] raddr;
   logic [NUM_READ-1:0][REG_WIDTH-1:0]  rdata;

   // Out-of-range write addresses match no decode line and are dropped.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      assign we[i] = write_enable && ({1'b0, write_addr} == (ADDR_WIDTH+1)'(i));
      if (i == 0 && REG_ZERO_GROUND) begin : g_zero
         assign regs[i] = '0;
      end else begin : g_store
         reg_cell #(.REG_WIDTH(REG_WIDTH)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we[i]),
            .d     (write_data),
            .q     (regs[i])
         );
      end
   end

   assign raddr[0] = read_addr_0;
   assign raddr[1] = read_addr_1;

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      reg_read_port #(
         .REG_WIDTH  (REG_WIDTH),
         .NUM_REGS   (NUM_REGS),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_port (
         .regs (regs),
         .addr (raddr[p]),
         .data (rdata[p])
      );
   end

   assign read_data_0 = rdata[0];
   assign read_data_1 = rdata[1];
endmodule

// File: tb/tb_register_controller.sv
// Bench: grounded 32-entry file (a) beside an ungrounded 24-entry file (b),
// both on the same buses; scoreboard queue of expected read data.
module tb_register_controller;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [4:0]  read_addr_0, read_addr_1;
   logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;

   int total = 0;
   int bad   = 0;
   logic [31:0] ma [32];
   logic [31:0] mb [32];
   logic [31:0] sb_q [$];

   always #5 clk = ~clk;

   register_controller #(.REG_WIDTH(32), .NUM_REGS(32), .REG_ZERO_GROUND(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
      .read_data_0(rd0_a), .read_data_1(rd1_a)
   );

   register_controller #(.REG_WIDTH(32), .NUM_REGS(24), .REG_ZERO_GROUND(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
      .read_data_0(rd0_b), .read_data_1(rd1_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_a(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : ma[a];
   endfunction

   function automatic logic [31:0] exp_b(input logic [4:0] a);
      return (a < 5'd24) ? mb[a] : 32'h0;
   endfunction

   task automatic clear_models();
      for (int i = 0; i < 32; i++) begin
         ma[i] = 32'h0;
         mb[i] = 32'h0;
      end
   endtask

   // Present read addresses, queue expectations, let reads settle, compare.
   task automatic rd(input string tag, input logic [4:0] a0, input logic [4:0] a1);
      read_addr_0 = a0;
      read_addr_1 = a1;
      sb_q.push_back(exp_a(a0));
      sb_q.push_back(exp_a(a1));
      sb_q.push_back(exp_b(a0));
      sb_q.push_back(exp_b(a1));
      #1;
      chk({tag, ".a0"}, rd0_a, sb_q.pop_front());
      chk({tag, ".a1"}, rd1_a, sb_q.pop_front());
      chk({tag, ".b0"}, rd0_b, sb_q.pop_front());
      chk({tag, ".b1"}, rd1_b, sb_q.pop_front());
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      write_enable = 1'b1;
      write_addr   = a;
      write_data   = d;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      if (a != 5'd0) ma[a] = d;
      if (a < 5'd24) mb[a] = d;
   endtask

   initial begin
      rst_n = 1'b0;
      write_enable = 1'b0;
      write_addr = '0;
      write_data = '0;
      read_addr_0 = '0;
      read_addr_1 = '0;
      clear_models();

      // Reset, including a write attempted while reset is held.
      write_enable = 1'b1;
      write_addr   = 5'd3;
      write_data   = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      write_enable = 1'b0;
      rd("reset", 5'd1, 5'd31);
      @(negedge clk);
      rst_n = 1'b1;
      rd("rst_wr_ignored", 5'd3, 5'd3);

      wr(5'd1, 32'hDEADBEEF);
      rd("wr1", 5'd1, 5'd2);

      wr(5'd0, 32'h12345678);
      rd("zero", 5'd0, 5'd0);

      wr(5'd31, 32'hAABBCCDD);
      rd("top", 5'd0, 5'd31);
      rd("dual", 5'd1, 5'd31);
      rd("same", 5'd31, 5'd31);

      // Out-of-range (dut_b) write is discarded, in-range boundary kept.
      wr(5'd23, 32'h0BAD_F00D);
      wr(5'd24, 32'h1111_2222);
      rd("bound", 5'd23, 5'd24);

      // No bypass: pending write is invisible until the edge.
      @(negedge clk);
      write_enable = 1'b1;
      write_addr   = 5'd5;
      write_data   = 32'h55AA55AA;
      rd("nobyp_pre", 5'd5, 5'd1);
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      ma[5] = 32'h55AA55AA;
      mb[5] = 32'h55AA55AA;
      rd("nobyp_post", 5'd5, 5'd1);

      // Random writes/reads against the models.
      for (int n = 0; n < 40; n++) begin
         wr(5'($urandom_range(0, 31)), $urandom);
         rd("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // Asynchronous mid-cycle reset, with a coincident write that is lost.
      @(negedge clk);
      read_addr_0 = 5'd1;
      read_addr_1 = 5'd5;
      write_enable = 1'b1;
      write_addr   = 5'd7;
      write_data   = 32'hCAFE_BABE;
      #2;
      rst_n = 1'b0;
      clear_models();
      rd("async_rst", 5'd1, 5'd5);
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      rd("rst_hold", 5'd7, 5'd31);
      @(negedge clk);
      rst_n = 1'b1;
      rd("after_rst", 5'd7, 5'd1);
      wr(5'd9, 32'h0000_0099);
      rd("post_wr", 5'd9, 5'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
